video_timing_gen: RTL and testbench

- Generates line/frame timing for the composite encoder path.
- Drives the strobes and flags the PAL/NTSC encoder consumes: newframe, newline, startburst, even_line, even_field.
- Also drives sync/blank/active flags for the downstream composite mixer, and pixel/line counters for the framebuffer reader.
- Progressive output ("240p/288p" style); one clk domain.

---
 rtl/video_timing_gen.sv | 229 ++++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Line/frame timing generator for the composite encoder path.
// Counters and all flags are registered; flags are decoded from next-state counters.

module video_timing_gen_param_check #(
    parameter int PAL_LINE_CLKS     = 3072,
    parameter int NTSC_LINE_CLKS    = 3051,
    parameter int PAL_LINES         = 312,
    parameter int NTSC_LINES        = 262,
    parameter int HSYNC_CLKS        = 226,
    parameter int BURST_START       = 269,
    parameter int ACTIVE_START      = 504,
    parameter int ACTIVE_END_OFFSET = 72,
    parameter int VSYNC_LINES       = 3,
    parameter int VBLANK_LINES      = 20
) ();

    if (PAL_LINE_CLKS < 1 || PAL_LINE_CLKS > 4096 ||
        NTSC_LINE_CLKS < 1 || NTSC_LINE_CLKS > 4096) begin : g_bad_line_clks
        $error("video_timing_gen: line clock counts must lie in 1..4096");
    end

    if (PAL_LINES < 1 || PAL_LINES > 512 ||
        NTSC_LINES < 1 || NTSC_LINES > 512) begin : g_bad_lines
        $error("video_timing_gen: line counts must lie in 1..512");
    end

    if (!(HSYNC_CLKS < BURST_START && BURST_START < ACTIVE_START &&
          ACTIVE_START < PAL_LINE_CLKS - ACTIVE_END_OFFSET &&
          ACTIVE_START < NTSC_LINE_CLKS - ACTIVE_END_OFFSET)) begin : g_bad_h_order
        $error("video_timing_gen: horizontal event ordering violated");
    end

    if (VBLANK_LINES < VSYNC_LINES || VBLANK_LINES > PAL_LINES ||
        VBLANK_LINES > NTSC_LINES) begin : g_bad_v_order
        $error("video_timing_gen: vertical blanking must cover the vsync lines");
    end

endmodule

module video_timing_gen #(
    parameter int PAL_LINE_CLKS     = 3072,
    parameter int NTSC_LINE_CLKS    = 3051,
    parameter int PAL_LINES         = 312,
    parameter int NTSC_LINES        = 262,
    parameter int HSYNC_CLKS        = 226,
    parameter int BURST_START       = 269,
    parameter int ACTIVE_START      = 504,
    parameter int ACTIVE_END_OFFSET = 72,
    parameter int VSYNC_LINES       = 3,
    parameter int VBLANK_LINES      = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pal_mode,
    output logic [11:0] h_count,
    output logic [8:0]  v_count,
    output logic        newline,
    output logic        newframe,
    output logic        startburst,
    output logic        even_line,
    output logic        even_field,
    output logic        sync,
    output logic        blank,
    output logic        active,
    output logic        pal_active
);

    localparam logic [11:0] PAL_LC    = 12'(PAL_LINE_CLKS);
    localparam logic [11:0] NTSC_LC   = 12'(NTSC_LINE_CLKS);
    localparam logic [8:0]  PAL_NL    = 9'(PAL_LINES);
    localparam logic [8:0]  NTSC_NL   = 9'(NTSC_LINES);
    localparam logic [11:0] HSYNC_W   = 12'(HSYNC_CLKS);
    localparam logic [11:0] BURST_W   = 12'(BURST_START);
    localparam logic [11:0] ASTART_W  = 12'(ACTIVE_START);
    localparam logic [11:0] AEO_W     = 12'(ACTIVE_END_OFFSET);
    localparam logic [8:0]  VSYNC_W   = 9'(VSYNC_LINES);
    localparam logic [8:0]  VBLANK_W  = 9'(VBLANK_LINES);

    localparam logic [11:0] PAL_LAST_H     = PAL_LC - 12'd1;
    localparam logic [11:0] NTSC_LAST_H    = NTSC_LC - 12'd1;
    localparam logic [8:0]  PAL_LAST_V     = PAL_NL - 9'd1;
    localparam logic [8:0]  NTSC_LAST_V    = NTSC_NL - 9'd1;
    localparam logic [11:0] PAL_BROAD_END  = PAL_LC - HSYNC_W;
    localparam logic [11:0] NTSC_BROAD_END = NTSC_LC - HSYNC_W;
    localparam logic [11:0] PAL_ACT_END    = PAL_LC - AEO_W;
    localparam logic [11:0] NTSC_ACT_END   = NTSC_LC - AEO_W;

    video_timing_gen_param_check #(
        .PAL_LINE_CLKS     (PAL_LINE_CLKS),
        .NTSC_LINE_CLKS    (NTSC_LINE_CLKS),
        .PAL_LINES         (PAL_LINES),
        .NTSC_LINES        (NTSC_LINES),
        .HSYNC_CLKS        (HSYNC_CLKS),
        .BURST_START       (BURST_START),
        .ACTIVE_START      (ACTIVE_START),
        .ACTIVE_END_OFFSET (ACTIVE_END_OFFSET),
        .VSYNC_LINES       (VSYNC_LINES),
        .VBLANK_LINES      (VBLANK_LINES)
    ) u_param_check ();

    logic [11:0] h_q, h_d;
    logic [8:0]  v_q, v_d;
    logic        pal_q, pal_d;
    logic        even_field_q, even_field_d;
    logic        newline_q, newline_d;
    logic        newframe_q, newframe_d;
    logic        startburst_q, startburst_d;
    logic        even_line_q, even_line_d;
    logic        sync_q, sync_d;
    logic        blank_q, blank_d;
    logic        active_q, active_d;

    logic [11:0] last_h_s;
    logic [8:0]  last_v_s;
    logic [11:0] broad_end_s;
    logic [11:0] act_end_s;
    logic        h_wrap_s;
    logic        frame_wrap_s;

    // Counter advance; the wrap decision uses the standard latched for the current frame.
    always_comb begin
        last_h_s     = NTSC_LAST_H;
        last_v_s     = NTSC_LAST_V;
        h_d          = h_q + 12'd1;
        v_d          = v_q;
        pal_d        = pal_q;
        even_field_d = even_field_q;

        if (pal_q) begin
            last_h_s = PAL_LAST_H;
            last_v_s = PAL_LAST_V;
        end else begin
            last_h_s = NTSC_LAST_H;
            last_v_s = NTSC_LAST_V;
        end

        h_wrap_s     = (h_q == last_h_s);
        frame_wrap_s = h_wrap_s && (v_q == last_v_s);

        if (frame_wrap_s) begin
            h_d          = 12'd0;
            v_d          = 9'd0;
            pal_d        = pal_mode;
            even_field_d = ~even_field_q;
        end else if (h_wrap_s) begin
            h_d = 12'd0;
            v_d = v_q + 9'd1;
        end else begin
            h_d = h_q + 12'd1;
            v_d = v_q;
        end
    end

    // Flag decode from next-state counters so flags line up with the counters they describe.
    always_comb begin
        broad_end_s  = NTSC_BROAD_END;
        act_end_s    = NTSC_ACT_END;
        newline_d    = 1'b0;
        newframe_d   = 1'b0;
        startburst_d = 1'b0;
        sync_d       = 1'b0;
        blank_d      = 1'b1;

        if (pal_d) begin
            broad_end_s = PAL_BROAD_END;
            act_end_s   = PAL_ACT_END;
        end else begin
            broad_end_s = NTSC_BROAD_END;
            act_end_s   = NTSC_ACT_END;
        end

        newline_d    = (h_d == 12'd0);
        newframe_d   = (h_d == 12'd0) && (v_d == 9'd0);
        even_line_d  = ~v_d[0];

        if (v_d < VSYNC_W) begin
            startburst_d = 1'b0;
            sync_d       = (h_d < broad_end_s);
        end else begin
            startburst_d = (h_d == BURST_W);
            sync_d       = (h_d < HSYNC_W);
        end

        blank_d  = (v_d < VBLANK_W) || (h_d < ASTART_W) || (h_d >= act_end_s);
        active_d = ~blank_d;
    end

    // State and output registers with asynchronous return to the idle frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q          <= 12'd0;
            v_q          <= 9'd0;
            pal_q        <= 1'b1;
            even_field_q <= 1'b0;
            newline_q    <= 1'b0;
            newframe_q   <= 1'b0;
            startburst_q <= 1'b0;
            even_line_q  <= 1'b1;
            sync_q       <= 1'b0;
            blank_q      <= 1'b1;
            active_q     <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            pal_q        <= pal_d;
            even_field_q <= even_field_d;
            newline_q    <= newline_d;
            newframe_q   <= newframe_d;
            startburst_q <= startburst_d;
            even_line_q  <= even_line_d;
            sync_q       <= sync_d;
            blank_q      <= blank_d;
            active_q     <= active_d;
        end
    end

    assign h_count    = h_q;
    assign v_count    = v_q;
    assign newline    = newline_q;
    assign newframe   = newframe_q;
    assign startburst = startburst_q;
    assign even_line  = even_line_q;
    assign even_field = even_field_q;
    assign sync       = sync_q;
    assign blank      = blank_q;
    assign active     = active_q;
    assign pal_active = pal_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using scaled-down line/frame parameters.

module tb_video_timing_gen;

    // Scaled timing: PAL 64 clks x 26 lines, NTSC 60 clks x 22 lines.
    localparam int P_LC = 64, N_LC = 60, P_NL = 26, N_NL = 22;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pal_mode = 1'b1;
    logic [11:0] h_count;
    logic [8:0]  v_count;
    logic        newline, newframe, startburst, even_line, even_field;
    logic        sync, blank, active, pal_active;

    video_timing_gen #(
        .PAL_LINE_CLKS(P_LC), .NTSC_LINE_CLKS(N_LC), .PAL_LINES(P_NL), .NTSC_LINES(N_NL),
        .HSYNC_CLKS(6), .BURST_START(9), .ACTIVE_START(16), .ACTIVE_END_OFFSET(4),
        .VSYNC_LINES(3), .VBLANK_LINES(5)
    ) dut (
        .clk(clk), .reset(reset), .pal_mode(pal_mode),
        .h_count(h_count), .v_count(v_count),
        .newline(newline), .newframe(newframe), .startburst(startburst),
        .even_line(even_line), .even_field(even_field),
        .sync(sync), .blank(blank), .active(active), .pal_active(pal_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ep;
        int          k;
        logic [11:0] h;
        logic [8:0]  v;
        logic [8:0]  fl;   // {newline,newframe,startburst,even_line,even_field,sync,blank,active,pal_active}
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   ep_cnt = 0;
    int   nl_cnt = 0, nf_cnt = 0, sb_cnt = 0;
    int   ntsc_max_v = 0;

    // Posedges since the last reset release, and reset epoch number.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(posedge reset) ep_cnt <= ep_cnt + 1;

    task automatic expv(input int ep, input int k, input int h, input int v, input logic [8:0] fl);
        exp_t e;
        e.ep = ep; e.k = k; e.h = 12'(h); e.v = 9'(v); e.fl = fl;
        sbq.push_back(e);
    endtask

    // Monitor: pops and compares whenever the DUT reaches the position an entry describes.
    always @(negedge clk) begin
        exp_t e;
        logic [8:0] act_fl;
        act_fl = {newline, newframe, startburst, even_line, even_field, sync, blank, active, pal_active};
        while (sbq.size() > 0 && (sbq[0].ep < ep_cnt || (sbq[0].ep == ep_cnt && sbq[0].k < cyc))) begin
            e = sbq.pop_front();
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL missed ep%0d k%0d: got no sample, want h=%0d v=%0d", e.ep, e.k, e.h, e.v);
        end
        if (sbq.size() > 0 && sbq[0].ep == ep_cnt && sbq[0].k == cyc) begin
            e = sbq.pop_front();
            tests = tests + 1;
            if (h_count !== e.h || v_count !== e.v || act_fl !== e.fl) begin
                fails = fails + 1;
                $display("FAIL vec ep%0d k%0d: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
                         e.ep, e.k, h_count, v_count, act_fl, e.h, e.v, e.fl);
            end
        end
        if (reset) begin
            nl_cnt = 0; nf_cnt = 0; sb_cnt = 0;
        end else begin
            nl_cnt = nl_cnt + int'(newline);
            nf_cnt = nf_cnt + int'(newframe);
            sb_cnt = sb_cnt + int'(startburst);
            if (!pal_active && int'(v_count) > ntsc_max_v) ntsc_max_v = int'(v_count);
        end
    end

    task automatic check_int(input string name, input int got, input int want);
        tests = tests + 1;
        if (got != want) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Epoch 1: PAL frame, NTSC frame (pal_mode dropped mid-frame), back to PAL.
        //                 flags: nl nf sb el ef sy bl ac pa
        expv(1,    0,  0,  0, 9'b0_0_0_1_0_0_1_0_1);
        expv(1,    1,  1,  0, 9'b0_0_0_1_0_1_1_0_1);
        expv(1,    9,  9,  0, 9'b0_0_0_1_0_1_1_0_1);
        expv(1,   57, 57,  0, 9'b0_0_0_1_0_1_1_0_1);
        expv(1,   58, 58,  0, 9'b0_0_0_1_0_0_1_0_1);
        expv(1,   64,  0,  1, 9'b1_0_0_0_0_1_1_0_1);
        expv(1,  137,  9,  2, 9'b0_0_0_1_0_1_1_0_1);
        expv(1,  192,  0,  3, 9'b1_0_0_0_0_1_1_0_1);
        expv(1,  197,  5,  3, 9'b0_0_0_0_0_1_1_0_1);
        expv(1,  198,  6,  3, 9'b0_0_0_0_0_0_1_0_1);
        expv(1,  201,  9,  3, 9'b0_0_1_0_0_0_1_0_1);
        expv(1,  272, 16,  4, 9'b0_0_0_1_0_0_1_0_1);
        expv(1,  335, 15,  5, 9'b0_0_0_0_0_0_1_0_1);
        expv(1,  336, 16,  5, 9'b0_0_0_0_0_0_0_1_1);
        expv(1,  379, 59,  5, 9'b0_0_0_0_0_0_0_1_1);
        expv(1,  380, 60,  5, 9'b0_0_0_0_0_0_1_0_1);
        expv(1, 1663, 63, 25, 9'b0_0_0_0_0_0_1_0_1);
        expv(1, 1664,  0,  0, 9'b1_1_0_1_1_1_1_0_0);
        expv(1, 1717, 53,  0, 9'b0_0_0_1_1_1_1_0_0);
        expv(1, 1718, 54,  0, 9'b0_0_0_1_1_0_1_0_0);
        expv(1, 1723, 59,  0, 9'b0_0_0_1_1_0_1_0_0);
        expv(1, 1724,  0,  1, 9'b1_0_0_0_1_1_1_0_0);
        expv(1, 1853,  9,  3, 9'b0_0_1_0_1_0_1_0_0);
        expv(1, 2019, 55,  5, 9'b0_0_0_0_1_0_0_1_0);
        expv(1, 2020, 56,  5, 9'b0_0_0_0_1_0_1_0_0);
        expv(1, 2983, 59, 21, 9'b0_0_0_0_1_0_1_0_0);
        expv(1, 2984,  0,  0, 9'b1_1_0_1_0_1_1_0_1);
        expv(1, 3047, 63,  0, 9'b0_0_0_1_0_0_1_0_1);
        expv(1, 3048,  0,  1, 9'b1_0_0_0_0_1_1_0_1);
        expv(1, 3644, 20, 10, 9'b0_0_0_1_0_0_0_1_1);

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (640) @(negedge clk);
        pal_mode = 1'b0;                      // v=10 of the first PAL frame
        repeat (2264 - 640) @(negedge clk);
        pal_mode = 1'b1;                      // mid NTSC frame
        repeat (3644 - 2264) @(negedge clk);

        // Epoch 2: reset mid-line with pal_mode low; reset value of pal_active wins.
        expv(2,    0,  0,  0, 9'b0_0_0_1_0_0_1_0_1);
        expv(2,    1,  1,  0, 9'b0_0_0_1_0_1_1_0_1);
        expv(2, 1663, 63, 25, 9'b0_0_0_0_0_0_1_0_1);
        expv(2, 1664,  0,  0, 9'b1_1_0_1_1_1_1_0_0);
        expv(2, 1728,  4,  1, 9'b0_0_0_0_1_1_1_0_0);
        @(posedge clk);
        #1;
        pal_mode = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (1728) @(negedge clk);
        @(posedge clk);
        #2;

        check_int("newline_count", nl_cnt, 27);
        check_int("newframe_count", nf_cnt, 1);
        check_int("startburst_count", sb_cnt, 23);
        check_int("ntsc_max_v", ntsc_max_v, N_NL - 1);
        check_int("scoreboard_left", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
